// File: rtl/sram_axi_slave_wrapper.sv
// -----------------------------------------------------------------------------
// sram_axi_slave_wrapper
//
// AXI4 slave front end for one synchronous single-port SRAM macro (IM/DM bank).
// Accepts one transaction at a time (single beat or INCR burst) and turns the
// AR/R and AW/W/B handshakes into SRAM chip-enable, write-enable and bit-mask
// cycles. Reads take two cycles per beat: one access cycle, then one cycle in
// which the SRAM output is presented on R.
//
// Ports
//   ACLK, ARESETn        clock, synchronous active-low reset
//   S_AR*                read address channel  (Size/Burst accepted, ignored)
//   S_R*                 read data channel     (RResp always OKAY)
//   S_AW*                write address channel (Size/Burst accepted, ignored)
//   S_W*                 write data channel    (byte select via WStrb)
//   S_B*                 write response        (SLVERR on WLast/len mismatch)
//   SRAM_CEB/WEB/BWEB    active-low chip enable, write enable, bit write mask
//   SRAM_A/DI/DO         word address, write data, read data (DO valid the
//                        cycle after a read access, held while CEB=1)
// -----------------------------------------------------------------------------
module sram_axi_slave_wrapper #(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // read address
  input  logic [ID_W-1:0]     S_ARID,
  input  logic [ADDR_W-1:0]   S_ARAddr,
  input  logic [LEN_W-1:0]    S_ARLen,
  input  logic [2:0]          S_ARSize,
  input  logic [1:0]          S_ARBurst,
  input  logic                S_ARValid,
  output logic                S_ARReady,
  // read data
  output logic [ID_W-1:0]     S_RID,
  output logic [DATA_W-1:0]   S_RData,
  output logic [1:0]          S_RResp,
  output logic                S_RLast,
  output logic                S_RValid,
  input  logic                S_RReady,
  // write address
  input  logic [ID_W-1:0]     S_AWID,
  input  logic [ADDR_W-1:0]   S_AWAddr,
  input  logic [LEN_W-1:0]    S_AWLen,
  input  logic [2:0]          S_AWSize,
  input  logic [1:0]          S_AWBurst,
  input  logic                S_AWValid,
  output logic                S_AWReady,
  // write data
  input  logic [DATA_W-1:0]   S_WData,
  input  logic [DATA_W/8-1:0] S_WStrb,
  input  logic                S_WLast,
  input  logic                S_WValid,
  output logic                S_WReady,
  // write response
  output logic [ID_W-1:0]     S_BID,
  output logic [1:0]          S_BResp,
  output logic                S_BValid,
  input  logic                S_BReady,
  // SRAM macro
  output logic                SRAM_CEB,
  output logic                SRAM_WEB,
  output logic [DATA_W-1:0]   SRAM_BWEB,
  output logic [SRAM_AW-1:0]  SRAM_A,
  output logic [DATA_W-1:0]   SRAM_DI,
  input  logic [DATA_W-1:0]   SRAM_DO
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    R_ACC  = 3'd1,
    R_DATA = 3'd2,
    W_DATA = 3'd3,
    W_RESP = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               err_q;
  logic               last_beat;

  // Size, burst type and the byte/upper address bits carry no information for
  // a full-word INCR-only SRAM port.
  logic unused_inputs;
  assign unused_inputs = ^{S_ARSize, S_ARBurst, S_AWSize, S_AWBurst,
                           S_ARAddr, S_AWAddr};

  assign last_beat = (cnt_q == len_q);

  // R and B are driven from registers only; ready never feeds back into valid.
  assign S_RID   = id_q;
  assign S_RData = SRAM_DO;   // CEB stays high in R_DATA, so DO is stable
  assign S_RResp = 2'b00;
  assign S_RLast = last_beat;
  assign S_BID   = id_q;
  assign S_BResp = err_q ? 2'b10 : 2'b00;
  assign SRAM_A  = addr_q;
  assign SRAM_DI = S_WData;

  // Next-state and handshake/SRAM strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can leave a value held (latch).
    state_d   = state_q;
    S_ARReady = 1'b0;
    S_AWReady = 1'b0;
    S_RValid  = 1'b0;
    S_WReady  = 1'b0;
    S_BValid  = 1'b0;
    SRAM_CEB  = 1'b1;
    SRAM_WEB  = 1'b1;
    SRAM_BWEB = '1;

    case (state_q)
      IDLE: begin
        S_ARReady = 1'b1;
        S_AWReady = !S_ARValid;            // read has priority
        if (S_ARValid)      state_d = R_ACC;
        else if (S_AWValid) state_d = W_DATA;
      end
      R_ACC: begin
        SRAM_CEB = 1'b0;
        state_d  = R_DATA;
      end
      R_DATA: begin
        S_RValid = 1'b1;
        if (S_RReady) state_d = last_beat ? IDLE : R_ACC;
      end
      W_DATA: begin
        S_WReady = 1'b1;
        if (S_WValid) begin
          SRAM_CEB = 1'b0;
          SRAM_WEB = 1'b0;
          for (int k = 0; k < DATA_W/8; k++)
            SRAM_BWEB[8*k +: 8] = {8{~S_WStrb[k]}};
          if (S_WLast) state_d = W_RESP;
        end
      end
      W_RESP: begin
        S_BValid = 1'b1;
        if (S_BReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset is synchronous, so the interface is forced quiet while it is held.
    if (!ARESETn) begin
      S_ARReady = 1'b0;
      S_AWReady = 1'b0;
      S_RValid  = 1'b0;
      S_WReady  = 1'b0;
      S_BValid  = 1'b0;
      SRAM_CEB  = 1'b1;
      SRAM_WEB  = 1'b1;
      SRAM_BWEB = '1;
    end
  end

  // Control state: the only registers that need a known value after reset.
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!ARESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (S_ARValid) begin
            cnt_q <= '0;
          end else if (S_AWValid) begin
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        R_DATA: if (S_RReady && !last_beat) cnt_q <= cnt_q + 1'b1;
        W_DATA: begin
          if (S_WValid) begin
            cnt_q <= cnt_q + 1'b1;
            if (S_WLast != last_beat) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Transaction datapath.
  // NOTE: id/addr/len are always loaded before use, so they carry no reset.
  always_ff @(posedge ACLK) begin
    case (state_q)
      IDLE: begin
        if (S_ARValid) begin
          id_q   <= S_ARID;
          addr_q <= S_ARAddr[SRAM_AW+1:2];
          len_q  <= S_ARLen;
        end else if (S_AWValid) begin
          id_q   <= S_AWID;
          addr_q <= S_AWAddr[SRAM_AW+1:2];
          len_q  <= S_AWLen;
        end
      end
      // addr_q is SRAM_AW bits wide, so the increment wraps at the top word.
      R_DATA: if (S_RReady && !last_beat) addr_q <= addr_q + 1'b1;
      W_DATA: if (S_WValid) addr_q <= addr_q + 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_axi_slave_wrapper.sv
// -----------------------------------------------------------------------------
// Directed testbench for sram_axi_slave_wrapper with a behavioural SRAM model.
// -----------------------------------------------------------------------------
module tb_sram_axi_slave_wrapper;

  localparam int ID_W = 8, ADDR_W = 32, DATA_W = 32, LEN_W = 4, SRAM_AW = 14;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [ID_W-1:0]    ar_id = '0, aw_id = '0, r_id, b_id;
  logic [ADDR_W-1:0]  ar_addr = '0, aw_addr = '0;
  logic [LEN_W-1:0]   ar_len = '0, aw_len = '0;
  logic [2:0]         ar_size = 3'd2, aw_size = 3'd2;
  logic [1:0]         ar_burst = 2'b01, aw_burst = 2'b01;
  logic               ar_valid = 1'b0, aw_valid = 1'b0, w_valid = 1'b0;
  logic               r_ready = 1'b0, b_ready = 1'b0, w_last = 1'b0;
  logic               ar_ready, aw_ready, r_valid, r_last, w_ready, b_valid;
  logic [DATA_W-1:0]  r_data, w_data = '0;
  logic [DATA_W/8-1:0] w_strb = '0;
  logic [1:0]         r_resp, b_resp;
  logic               sram_ceb, sram_web;
  logic [DATA_W-1:0]  sram_bweb, sram_di, sram_do;
  logic [SRAM_AW-1:0] sram_a;

  int n_checks = 0;
  int n_fail   = 0;

  sram_axi_slave_wrapper #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SRAM_AW(SRAM_AW)
  ) dut (
    .ACLK(aclk), .ARESETn(aresetn),
    .S_ARID(ar_id), .S_ARAddr(ar_addr), .S_ARLen(ar_len), .S_ARSize(ar_size),
    .S_ARBurst(ar_burst), .S_ARValid(ar_valid), .S_ARReady(ar_ready),
    .S_RID(r_id), .S_RData(r_data), .S_RResp(r_resp), .S_RLast(r_last),
    .S_RValid(r_valid), .S_RReady(r_ready),
    .S_AWID(aw_id), .S_AWAddr(aw_addr), .S_AWLen(aw_len), .S_AWSize(aw_size),
    .S_AWBurst(aw_burst), .S_AWValid(aw_valid), .S_AWReady(aw_ready),
    .S_WData(w_data), .S_WStrb(w_strb), .S_WLast(w_last), .S_WValid(w_valid),
    .S_WReady(w_ready),
    .S_BID(b_id), .S_BResp(b_resp), .S_BValid(b_valid), .S_BReady(b_ready),
    .SRAM_CEB(sram_ceb), .SRAM_WEB(sram_web), .SRAM_BWEB(sram_bweb),
    .SRAM_A(sram_a), .SRAM_DI(sram_di), .SRAM_DO(sram_do)
  );

  // Behavioural single-port SRAM: bit-masked write, registered read output
  // that holds while the macro is deselected.
  logic [DATA_W-1:0] tb_mem [0:(1<<SRAM_AW)-1];
  int wr_count = 0;
  always @(posedge aclk) begin
    if (!sram_ceb) begin
      if (!sram_web) begin
        tb_mem[sram_a] <= (tb_mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
        wr_count <= wr_count + 1;
      end else begin
        sram_do <= tb_mem[sram_a];
      end
    end
  end

  // Values captured during the most recent handshake.
  logic [SRAM_AW-1:0] cap_a;
  logic [DATA_W-1:0]  cap_bweb, cap_di, cap_rdata;
  logic               cap_ceb, cap_web, cap_rlast;
  logic [ID_W-1:0]    cap_id;
  logic [1:0]         cap_resp;

  // ---------------- channel drivers (enter/leave just after a posedge) -------
  task automatic do_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                       input logic [LEN_W-1:0] len);
    logic hs;
    hs = 1'b0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_valid = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      #1; hs = aw_ready;
      @(posedge aclk); #1;
    end
    aw_valid = 1'b0;
    n_checks++;
    if (hs !== 1'b1) begin n_fail++; $display("FAIL aw_handshake: AWReady not seen in 20 cycles"); end
  endtask

  task automatic do_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                       input logic [LEN_W-1:0] len);
    logic hs;
    hs = 1'b0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_valid = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      #1; hs = ar_ready;
      @(posedge aclk); #1;
    end
    ar_valid = 1'b0;
    n_checks++;
    if (hs !== 1'b1) begin n_fail++; $display("FAIL ar_handshake: ARReady not seen in 20 cycles"); end
  endtask

  task automatic do_w(input logic [DATA_W-1:0] data, input logic [DATA_W/8-1:0] strb,
                      input logic last);
    logic hs;
    hs = 1'b0;
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      #1; hs = w_ready;
      if (hs) begin
        cap_ceb = sram_ceb; cap_web = sram_web; cap_a = sram_a;
        cap_bweb = sram_bweb; cap_di = sram_di;
      end
      @(posedge aclk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    n_checks++;
    if (hs !== 1'b1) begin n_fail++; $display("FAIL w_handshake: WReady not seen in 20 cycles"); end
  endtask

  task automatic do_b();
    logic hs;
    hs = 1'b0;
    b_ready = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      #1; hs = b_valid;
      if (hs) begin cap_id = b_id; cap_resp = b_resp; end
      @(posedge aclk); #1;
    end
    b_ready = 1'b0;
    n_checks++;
    if (hs !== 1'b1) begin n_fail++; $display("FAIL b_handshake: BValid not seen in 20 cycles"); end
  endtask

  task automatic do_r();
    logic hs;
    hs = 1'b0;
    r_ready = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      #1; hs = r_valid;
      if (hs) begin cap_rdata = r_data; cap_rlast = r_last; cap_id = r_id; end
      @(posedge aclk); #1;
    end
    r_ready = 1'b0;
    n_checks++;
    if (hs !== 1'b1) begin n_fail++; $display("FAIL r_handshake: RValid not seen in 20 cycles"); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 1'b0; ar_valid = 1'b1; ar_addr = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge aclk); #1;
      n_checks++;
      if ({ar_ready, aw_ready, r_valid, w_ready, b_valid, sram_ceb, sram_web} !== 7'b0000011) begin
        n_fail++;
        $display("FAIL reset_ctrl cycle %0d: got %b want 0000011", c,
                 {ar_ready, aw_ready, r_valid, w_ready, b_valid, sram_ceb, sram_web});
      end
      n_checks++;
      if (sram_bweb !== 32'hFFFF_FFFF) begin
        n_fail++; $display("FAIL reset_bweb: got %h want ffffffff", sram_bweb);
      end
    end
    aresetn = 1'b1; ar_valid = 1'b0;
    #1;
    n_checks++;
    if ({ar_ready, aw_ready, r_valid, b_valid} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_release: got %b want 1100", {ar_ready, aw_ready, r_valid, b_valid});
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_single_rw();
    @(posedge aclk); #1;
    do_aw(8'hA5, 32'h0000_0010, 4'd0);
    do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    n_checks++;
    if ({cap_ceb, cap_web, cap_a, cap_bweb, cap_di} !== {2'b00, 14'h0004, 32'h0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL single_write_sram: ceb/web=%b%b a=%h bweb=%h di=%h want 00 0004 00000000 deadbeef",
               cap_ceb, cap_web, cap_a, cap_bweb, cap_di);
    end
    do_b();
    n_checks++;
    if ({cap_id, cap_resp} !== {8'hA5, 2'b00}) begin
      n_fail++; $display("FAIL single_write_b: id=%h resp=%b want a5 00", cap_id, cap_resp);
    end
    // Read with explicit latency: handshake in cycle T, RValid in T+2.
    ar_id = 8'h3C; ar_addr = 32'h0000_0010; ar_len = 4'd0; ar_valid = 1'b1;
    #1;
    n_checks++;
    if (ar_ready !== 1'b1) begin n_fail++; $display("FAIL read_ar_ready: got %b want 1", ar_ready); end
    @(posedge aclk); #1;
    ar_valid = 1'b0;
    #1;
    n_checks++;
    if ({r_valid, sram_ceb, sram_web, sram_a} !== {3'b001, 14'h0004}) begin
      n_fail++;
      $display("FAIL read_t1: rvalid/ceb/web=%b%b%b a=%h want 001 0004", r_valid, sram_ceb, sram_web, sram_a);
    end
    @(posedge aclk); #2;
    n_checks++;
    if ({r_valid, r_data, r_last, r_id, r_resp} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 8'h3C, 2'b00}) begin
      n_fail++;
      $display("FAIL read_t2: valid=%b data=%h last=%b id=%h resp=%b want 1 deadbeef 1 3c 00",
               r_valid, r_data, r_last, r_id, r_resp);
    end
    r_ready = 1'b1;
    @(posedge aclk); #1;
    r_ready = 1'b0;
    #1;
    n_checks++;
    if ({r_valid, ar_ready} !== 2'b01) begin
      n_fail++; $display("FAIL read_done: rvalid/arready=%b want 01", {r_valid, ar_ready});
    end
  endtask

  task automatic test_byte_strobe();
    @(posedge aclk); #1;
    do_aw(8'h11, 32'h0000_0020, 4'd0);
    do_w(32'hFFFF_FFFF, 4'hF, 1'b1);
    do_b();
    do_aw(8'h12, 32'h0000_0020, 4'd0);
    do_w(32'h1122_3344, 4'b0101, 1'b1);
    n_checks++;
    if (cap_bweb !== 32'hFF00_FF00) begin
      n_fail++; $display("FAIL strobe_bweb: got %h want ff00ff00", cap_bweb);
    end
    do_b();
    do_ar(8'h13, 32'h0000_0020, 4'd0);
    do_r();
    n_checks++;
    if ({cap_rdata, cap_rlast} !== {32'hFF22_FF44, 1'b1}) begin
      n_fail++; $display("FAIL strobe_readback: data=%h last=%b want ff22ff44 1", cap_rdata, cap_rlast);
    end
  endtask

  task automatic test_burst_wrap();
    logic [DATA_W-1:0]  d     [0:3];
    logic [SRAM_AW-1:0] exp_a [0:3];
    logic hs;
    d     = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    @(posedge aclk); #1;
    do_aw(8'h21, 32'h0001_FFF8, 4'd3);
    for (int i = 0; i < 4; i++) begin
      do_w(d[i], 4'hF, i == 3);
      n_checks++;
      if (cap_a !== exp_a[i]) begin
        n_fail++; $display("FAIL burst_waddr beat %0d: got %h want %h", i, cap_a, exp_a[i]);
      end
    end
    do_b();
    n_checks++;
    if (cap_resp !== 2'b00) begin n_fail++; $display("FAIL burst_bresp: got %b want 00", cap_resp); end
    do_ar(8'h22, 32'h0001_FFF8, 4'd3);
    for (int i = 0; i < 2; i++) begin
      do_r();
      n_checks++;
      if ({cap_rdata, cap_rlast} !== {d[i], 1'b0}) begin
        n_fail++; $display("FAIL burst_rbeat %0d: data=%h last=%b want %h 0", i, cap_rdata, cap_rlast, d[i]);
      end
    end
    // Stall beat 3 for three cycles with RReady low.
    hs = 1'b0;
    for (int n = 0; n < 10 && !hs; n++) begin
      #1; hs = r_valid;
      if (!hs) begin @(posedge aclk); #1; end
    end
    n_checks++;
    if (hs !== 1'b1) begin n_fail++; $display("FAIL burst_stall_wait: RValid not seen"); end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({r_valid, r_data, r_last} !== {1'b1, d[2], 1'b0}) begin
        n_fail++;
        $display("FAIL burst_stall cycle %0d: valid=%b data=%h last=%b want 1 %h 0", c, r_valid, r_data, r_last, d[2]);
      end
      @(posedge aclk); #2;
    end
    for (int i = 2; i < 4; i++) begin
      do_r();
      n_checks++;
      if ({cap_rdata, cap_rlast} !== {d[i], i == 3}) begin
        n_fail++; $display("FAIL burst_rbeat %0d: data=%h last=%b want %h %b", i, cap_rdata, cap_rlast, d[i], i == 3);
      end
    end
  endtask

  task automatic test_early_wlast();
    int base;
    @(posedge aclk); #1;
    base = wr_count;
    do_aw(8'h51, 32'h0000_0100, 4'd3);
    do_w(32'hC0C0_C0C0, 4'hF, 1'b0);
    n_checks++;
    if (cap_a !== 14'h0040) begin n_fail++; $display("FAIL early_addr0: got %h want 0040", cap_a); end
    do_w(32'hC1C1_C1C1, 4'hF, 1'b1);
    n_checks++;
    if (cap_a !== 14'h0041) begin n_fail++; $display("FAIL early_addr1: got %h want 0041", cap_a); end
    #1;
    n_checks++;
    if ({w_ready, b_valid} !== 2'b01) begin
      n_fail++; $display("FAIL early_wresp_state: wready/bvalid=%b want 01", {w_ready, b_valid});
    end
    do_b();
    n_checks++;
    if ({cap_id, cap_resp} !== {8'h51, 2'b10}) begin
      n_fail++; $display("FAIL early_bresp: id=%h resp=%b want 51 10", cap_id, cap_resp);
    end
    #1;
    n_checks++;
    if ({ar_ready, wr_count - base} !== {1'b1, 32'd2}) begin
      n_fail++; $display("FAIL early_idle_writes: arready=%b writes=%0d want 1 2", ar_ready, wr_count - base);
    end
  endtask

  task automatic test_extra_beat();
    @(posedge aclk); #1;
    do_aw(8'h61, 32'h0000_0200, 4'd0);
    do_w(32'hE0E0_E0E0, 4'hF, 1'b0);
    do_w(32'hE1E1_E1E1, 4'hF, 1'b1);
    n_checks++;
    if (cap_a !== 14'h0081) begin n_fail++; $display("FAIL extra_addr: got %h want 0081", cap_a); end
    do_b();
    n_checks++;
    if (cap_resp !== 2'b10) begin n_fail++; $display("FAIL extra_bresp: got %b want 10", cap_resp); end
    do_ar(8'h62, 32'h0000_0200, 4'd1);
    do_r();
    n_checks++;
    if ({cap_rdata, cap_rlast, cap_id} !== {32'hE0E0_E0E0, 1'b0, 8'h62}) begin
      n_fail++; $display("FAIL extra_r0: data=%h last=%b id=%h want e0e0e0e0 0 62", cap_rdata, cap_rlast, cap_id);
    end
    do_r();
    n_checks++;
    if ({cap_rdata, cap_rlast} !== {32'hE1E1_E1E1, 1'b1}) begin
      n_fail++; $display("FAIL extra_r1: data=%h last=%b want e1e1e1e1 1", cap_rdata, cap_rlast);
    end
  endtask

  task automatic test_simultaneous();
    @(posedge aclk); #1;
    ar_id = 8'h41; ar_addr = 32'h0000_0010; ar_len = 4'd0; ar_valid = 1'b1;
    aw_id = 8'h42; aw_addr = 32'h0000_0040; aw_len = 4'd0; aw_valid = 1'b1;
    #1;
    n_checks++;
    if ({ar_ready, aw_ready} !== 2'b10) begin
      n_fail++; $display("FAIL simul_priority: arready/awready=%b want 10", {ar_ready, aw_ready});
    end
    @(posedge aclk); #1;
    ar_valid = 1'b0;
    #1;
    n_checks++;
    if (aw_ready !== 1'b0) begin n_fail++; $display("FAIL simul_racc_awready: got %b want 0", aw_ready); end
    @(posedge aclk); #2;
    n_checks++;
    if ({aw_ready, r_valid, r_data} !== {2'b01, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL simul_rdata: awready=%b rvalid=%b data=%h want 0 1 deadbeef", aw_ready, r_valid, r_data);
    end
    r_ready = 1'b1;
    @(posedge aclk); #1;
    r_ready = 1'b0;
    #1;
    n_checks++;
    if ({aw_ready, r_valid} !== 2'b10) begin
      n_fail++; $display("FAIL simul_aw_after_read: awready/rvalid=%b want 10", {aw_ready, r_valid});
    end
    @(posedge aclk); #1;
    aw_valid = 1'b0;
    #1;
    n_checks++;
    if (w_ready !== 1'b1) begin n_fail++; $display("FAIL simul_wdata_state: wready=%b want 1", w_ready); end
    do_w(32'h55AA_55AA, 4'hF, 1'b1);
    n_checks++;
    if (cap_a !== 14'h0010) begin n_fail++; $display("FAIL simul_waddr: got %h want 0010", cap_a); end
    do_b();
    n_checks++;
    if ({cap_id, cap_resp} !== {8'h42, 2'b00}) begin
      n_fail++; $display("FAIL simul_b: id=%h resp=%b want 42 00", cap_id, cap_resp);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(posedge aclk); #1;
    do_ar(8'h31, 32'h0001_FFF8, 4'd3);
    do_r();
    n_checks++;
    if (cap_rdata !== 32'hA0A0_0001) begin
      n_fail++; $display("FAIL midrst_beat0: got %h want a0a00001", cap_rdata);
    end
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    r_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if ({r_valid, ar_ready} !== 2'b01) begin
        n_fail++; $display("FAIL midrst_quiet cycle %0d: rvalid/arready=%b want 01", c, {r_valid, ar_ready});
      end
      @(posedge aclk); #1;
    end
    r_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_rw();
    test_byte_strobe();
    test_burst_wrap();
    test_early_wlast();
    test_extra_beat();
    test_simultaneous();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
